// File: rtl/grammer_checker.sv
// Golden-model scoreboard for the 4-entry transform-array stream block: predicts every output word and counts mismatches.
// Optional macro CHECKER_STOP_ON_ERR_EN: the first mismatch ends the run in a FAIL state with counters frozen.
module grammer_checker #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DUT_LAT    = 0,
  parameter int unsigned NUM_CHECKS = 1024,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  chk_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ERR_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  // Run counter is wide enough to reach NUM_CHECKS even when ERR_W is narrower.
  localparam int unsigned REQ_W = $clog2(NUM_CHECKS + 1);
  localparam int unsigned CNT_W = (REQ_W > ERR_W) ? REQ_W : ERR_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

  state_t              state_q;
  logic                busy_q, done_q, pass_q;
  logic [CNT_W-1:0]    run_cnt_q;
  logic [ERR_W-1:0]    err_cnt_q, first_idx_q;
  logic [DATA_W-1:0]   first_exp_q, first_got_q;

  logic [1:0]          addr_q;
  logic [7:0]          ph_q;
  logic [DATA_W-1:0]   temp_q;
  logic [DATA_W-1:0]   shadow_q [4];
  logic [3:0]          valid_q;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic                exp_v_q, exp_vd;

  logic                mism_c, last_c;
  logic [CNT_W-1:0]    run_cnt_d;
  logic [ERR_W-1:0]    err_cnt_d;

  function automatic logic [DATA_W-1:0] xform(input logic [7:0] ph, input logic [DATA_W-1:0] t);
    if (ph == 8'd0)  return t % DATA_W'(5);
    else if (!ph[7]) return t >> 1;
    else if (!ph[6]) return t >> 2;
    else             return '0;
  endfunction

  // Reference model of the transform array; runs in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      ph_q    <= '0;
      temp_q  <= '0;
      valid_q <= '0;
      exp_q   <= '0;
      exp_v_q <= 1'b0;
    end else begin
      addr_q          <= addr_q + 2'd1;
      ph_q            <= ph_q + 8'd1;
      temp_q          <= in;
      valid_q[addr_q] <= 1'b1;
      exp_q           <= shadow_q[addr_q];
      exp_v_q         <= valid_q[addr_q];
    end
  end

  // Shadow data needs no reset: valid_q masks stale entries.
  always_ff @(posedge clk) begin
    if (!reset) shadow_q[addr_q] <= xform(ph_q, temp_q);
  end

  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign exp_d  = exp_q;
      assign exp_vd = exp_v_q;
    end else begin : g_lat
      logic [DATA_W-1:0]  pipe_q [DUT_LAT];
      logic [DUT_LAT-1:0] pipev_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DUT_LAT; i++) pipe_q[i] <= '0;
          pipev_q <= '0;
        end else begin
          pipe_q[0]  <= exp_q;
          pipev_q[0] <= exp_v_q;
          for (int i = 1; i < DUT_LAT; i++) begin
            pipe_q[i]  <= pipe_q[i-1];
            pipev_q[i] <= pipev_q[i-1];
          end
        end
      end
      assign exp_d  = pipe_q[DUT_LAT-1];
      assign exp_vd = pipev_q[DUT_LAT-1];
    end
  endgenerate

  always_comb begin
    mism_c    = exp_vd && (dut_out != exp_d);
    run_cnt_d = run_cnt_q + CNT_W'(1);
    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    last_c    = (run_cnt_d == CNT_W'(NUM_CHECKS));
  end

  // Run control FSM with registered status and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      run_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (exp_vd) begin
            run_cnt_q <= run_cnt_d;
            if (mism_c) begin
              err_cnt_q <= err_cnt_d;
              if (err_cnt_q == '0) begin
                first_idx_q <= run_cnt_q[ERR_W-1:0];
                first_exp_q <= exp_d;
                first_got_q <= dut_out;
              end
            end
            if (last_c) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_q == '0) && !mism_c;
            end
`ifdef CHECKER_STOP_ON_ERR_EN
            if (mism_c) begin
              state_q <= S_FAIL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b0;
            end
`endif
          end
        end
        default: begin
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            run_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign chk_cnt       = run_cnt_q[ERR_W-1:0];
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_idx_q;
  assign first_err_exp = first_exp_q;
  assign first_err_got = first_got_q;

endmodule

// File: tb/tb_grammer_checker.sv
// Directed bench for grammer_checker: the bench plays the transform-array DUT and checks the scoreboard's verdicts.
module tb_grammer_checker;

  localparam int HIST = 2048;

  logic        clk = 1'b0;
  logic        reset, start, start_s;
  logic [31:0] din, dut_out, dut_out_s;

  logic        busy, done, pass;
  logic [15:0] chk_cnt, err_cnt, first_err_idx;
  logic [31:0] first_err_exp, first_err_got;

  logic        busy_s, done_s, pass_s;
  logic [3:0]  chk_cnt_s, err_cnt_s, first_err_idx_s;
  logic [31:0] first_err_exp_s, first_err_got_s;

  logic [31:0] in_hist [HIST];
  int          n;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  grammer_checker u_dut (
    .clk(clk), .reset(reset), .start(start), .in(din), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  grammer_checker #(.DATA_W(32), .DUT_LAT(2), .NUM_CHECKS(40), .ERR_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start_s), .in(din), .dut_out(dut_out_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .chk_cnt(chk_cnt_s), .err_cnt(err_cnt_s),
    .first_err_idx(first_err_idx_s), .first_err_exp(first_err_exp_s), .first_err_got(first_err_got_s)
  );

  // n = non-reset edges since the last reset edge; outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    n = reset ? 0 : n + 1;
    #1;
  endtask

  task automatic set_in(input logic [31:0] v);
    din = v;
    if (n >= 0 && n < HIST) in_hist[n] = v;
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1; start = 1'b0; start_s = 1'b0; dut_out = '0; dut_out_s = '0;
    repeat (cyc) tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] vary(input int m);
    return (32'(m) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Correct DUT word after m edges: entry written 4 edges earlier from the previous cycle's input
  function automatic logic [31:0] pred(input int m);
    int k, ph;
    logic [31:0] t;
    if (m < 5) return 32'h0;
    k  = m - 4;
    ph = (k - 1) % 256;
    t  = (k >= 2 && k - 2 < HIST) ? in_hist[k-2] : 32'h0;
    if (ph == 0)   return t % 32'd5;
    if (ph < 128)  return t >> 1;
    if (ph < 192)  return t >> 2;
    return 32'h0;
  endfunction

  // Hand table for a constant input: c0 at ph0, c1 at ph1..127, c2 at ph128..191, 0 otherwise
  function automatic logic [31:0] hand(input int m, input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
    int ph;
    if (m <= 5) return 32'h0;
    ph = (m - 5) % 256;
    if (ph == 0)  return c0;
    if (ph < 128) return c1;
    if (ph < 192) return c2;
    return 32'h0;
  endfunction

  task automatic run_const(input logic [31:0] v, input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input int start_n, output int done_n);
    done_n = -1;
    for (int i = 0; i < 1200 && done_n < 0; i++) begin
      set_in(v);
      start   = (n == start_n);
      dut_out = hand(n, c0, c1, c2);
      tick();
      if (done) done_n = n;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    din = 32'hA;
    do_reset(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0h want 0", pass); end
    checks++; if (chk_cnt !== 16'h0) begin errors++; $display("FAIL reset_chk got %0h want 0", chk_cnt); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err got %0h want 0", err_cnt); end
    checks++; if (first_err_exp !== 32'h0) begin errors++; $display("FAIL reset_fexp got %0h want 0", first_err_exp); end
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done_s got %0h want 0", done_s); end
  endtask

  task automatic test_const_a();
    int dn;
    din = 32'hA;
    do_reset(3);
    run_const(32'hA, 32'h0, 32'h5, 32'h2, 1, dn);
    checks++; if (dn !== 1029) begin errors++; $display("FAIL a_done_cycle got %0d want 1029", dn); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL a_pass got %0h want 1", pass); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL a_err got %0h want 0", err_cnt); end
    checks++; if (chk_cnt !== 16'd1024) begin errors++; $display("FAIL a_chk got %0d want 1024", chk_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a_busy got %0h want 0", busy); end
    // garbage in DONE must be ignored
    for (int i = 0; i < 6; i++) begin
      set_in(32'hA); dut_out = 32'hDEADBEEF; tick();
    end
    checks++; if (chk_cnt !== 16'd1024) begin errors++; $display("FAIL a_hold_chk got %0d want 1024", chk_cnt); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL a_hold_err got %0h want 0", err_cnt); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL a_hold_pass got %0h want 1", pass); end
  endtask

  task automatic test_const_64();
    int dn;
    do_reset(1);
    run_const(32'h64, 32'h0, 32'h32, 32'h19, 0, dn);
    checks++; if (dn !== 1029) begin errors++; $display("FAIL c64_done_cycle got %0d want 1029", dn); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL c64_err got %0h want 0", err_cnt); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL c64_pass got %0h want 1", pass); end
  endtask

  task automatic test_full_width();
    int dn;
    do_reset(1);
    run_const(32'hFFFFFFFE, 32'h4, 32'h7FFFFFFF, 32'h3FFFFFFF, 0, dn);
    checks++; if (dn !== 1029) begin errors++; $display("FAIL fw_done_cycle got %0d want 1029", dn); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL fw_err got %0h want 0", err_cnt); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL fw_pass got %0h want 1", pass); end
  endtask

  task automatic test_single_error();
    int dn, guard;
    logic [31:0] e10;
    do_reset(1);
    guard = 0;
    while (n < 11 && guard < 50) begin
      set_in(vary(n)); start = (n == 0);
      dut_out = pred(n) ^ ((n == 10) ? 32'h1 : 32'h0);
      tick(); guard++;
    end
    start = 1'b0;
    e10 = pred(10);
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL se_err got %0d want 1", err_cnt); end
    checks++; if (chk_cnt !== 16'd6) begin errors++; $display("FAIL se_chk got %0d want 6", chk_cnt); end
    checks++; if (first_err_idx !== 16'd5) begin errors++; $display("FAIL se_idx got %0d want 5", first_err_idx); end
    checks++; if (first_err_exp !== e10) begin errors++; $display("FAIL se_fexp got %0h want %0h", first_err_exp, e10); end
    checks++; if (first_err_got !== (e10 ^ 32'h1)) begin errors++; $display("FAIL se_fgot got %0h want %0h", first_err_got, e10 ^ 32'h1); end
`ifdef CHECKER_STOP_ON_ERR_EN
    checks++; if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL se_failstate got d%0h b%0h p%0h want d1 b0 p0", done, busy, pass); end
    for (int i = 0; i < 4; i++) begin set_in(vary(n)); dut_out = 32'hFFFF0000; tick(); end
    checks++; if (chk_cnt !== 16'd6) begin errors++; $display("FAIL se_frozen_chk got %0d want 6", chk_cnt); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL se_frozen_err got %0d want 1", err_cnt); end
    set_in(vary(n)); start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || chk_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL se_restart got b%0h c%0d e%0d want b1 c0 e0", busy, chk_cnt, err_cnt); end
    dn = 0;
`else
    dn = -1;
    for (guard = 0; guard < 1200 && dn < 0; guard++) begin
      set_in(vary(n)); start = (n == 300); dut_out = pred(n);
      tick();
      if (done) dn = n;
    end
    start = 1'b0;
    checks++; if (dn !== 1029) begin errors++; $display("FAIL se_done_cycle got %0d want 1029", dn); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL se_pass got %0h want 0", pass); end
    checks++; if (chk_cnt !== 16'd1024) begin errors++; $display("FAIL se_final_chk got %0d want 1024", chk_cnt); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL se_final_err got %0d want 1", err_cnt); end
    checks++; if (first_err_idx !== 16'd5) begin errors++; $display("FAIL se_final_idx got %0d want 5", first_err_idx); end
`endif
  endtask

  task automatic test_reset_midrun();
    int dn, guard;
    do_reset(1);
    for (guard = 0; guard < 300 && chk_cnt !== 16'd100; guard++) begin
      set_in(vary(n)); start = (n == 0); dut_out = pred(n);
      tick();
    end
    checks++; if (n !== 105) begin errors++; $display("FAIL mr_hit100 got %0d want 105", n); end
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mr_status got b%0h d%0h want b0 d0", busy, done); end
    checks++; if (chk_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL mr_counts got c%0d e%0d want c0 e0", chk_cnt, err_cnt); end
    run_const(32'hA, 32'h0, 32'h5, 32'h2, 0, dn);
    checks++; if (dn !== 1029) begin errors++; $display("FAIL mr_rerun_cycle got %0d want 1029", dn); end
    checks++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin errors++; $display("FAIL mr_rerun_pass got p%0h e%0d want p1 e0", pass, err_cnt); end
  endtask

  task automatic test_latency();
    int dn;
    do_reset(2);
    dn = -1;
    for (int i = 0; i < 200 && dn < 0; i++) begin
      set_in(vary(n)); start_s = (n == 0);
      dut_out_s = (n >= 2) ? pred(n - 2) : 32'h0;
      tick();
      if (done_s) dn = n;
    end
    start_s = 1'b0;
    checks++; if (dn !== 47) begin errors++; $display("FAIL lat_done_cycle got %0d want 47", dn); end
    checks++; if (pass_s !== 1'b1 || err_cnt_s !== 4'h0) begin errors++; $display("FAIL lat_pass got p%0h e%0h want p1 e0", pass_s, err_cnt_s); end
  endtask

  task automatic test_saturate();
    int dn;
    do_reset(2);
    dn = -1;
    for (int i = 0; i < 200 && dn < 0; i++) begin
      set_in(32'h0); start_s = (n == 0); dut_out_s = 32'hFFFFFFFF;
      tick();
      if (done_s) dn = n;
    end
    start_s = 1'b0;
    checks++; if (dn !== 47) begin errors++; $display("FAIL sat_done_cycle got %0d want 47", dn); end
    checks++; if (err_cnt_s !== 4'hF) begin errors++; $display("FAIL sat_err got %0h want f", err_cnt_s); end
    checks++; if (pass_s !== 1'b0) begin errors++; $display("FAIL sat_pass got %0h want 0", pass_s); end
  endtask

  initial begin
    n = 0;
    test_reset();
    test_const_a();
    test_const_64();
    test_full_width();
    test_single_error();
    test_reset_midrun();
    test_latency();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
